oled_spi_sink: RTL and testbench

OLED_SPI_SINK -- requirements
Module: oled_spi_sink

---
 rtl/oled_pkg.sv | 36 +++
 rtl/spi_byte_rx.sv | 100 ++++++++++
 rtl/oled_spi_sink.sv | 138 +++++++++++++
 tb/tb_oled_spi_sink.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
//==============================================================================
// Module      : oled_pkg
// Description : Shared constants and command-classification helpers for the
//               OLED SPI sink.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package oled_pkg;

  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;

  localparam int unsigned NUM_COLS  = 128;
  localparam int unsigned NUM_PAGES = 4;
  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned PAGE_W    = $clog2(NUM_PAGES);
  localparam int unsigned FB_ADDR_W = PAGE_W + COL_W;

  function automatic logic is_col_lo(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

  function automatic logic is_col_hi(input logic [7:0] b);
    return (b[7:3] == 5'b00010);
  endfunction

  function automatic logic is_page_set(input logic [7:0] b);
    return ((b & 8'hFC) == CMD_PAGE_BASE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
//==============================================================================
// Module      : spi_byte_rx
// Description : SPI mode-3 byte deserialiser with input synchronisers, SCLK
//               rising-edge detect, bit counter and sticky framing error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_byte_rx (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cs_i,
  input  logic       sclk_i,
  input  logic       sdin_i,
  input  logic       dc_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_dc_o,
  output logic       frame_err_o
);

  logic [1:0] cs_sync_q;
  logic [1:0] sclk_sync_q;
  logic [1:0] sdin_sync_q;
  logic [1:0] dc_sync_q;
  logic       sclk_prev_q;

  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d;
  logic       err_q, err_d;

  logic cs_s, sclk_s, sdin_s, dc_s, sclk_rise;

  assign cs_s      = cs_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign sdin_s    = sdin_sync_q[1];
  assign dc_s      = dc_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // SDIN/DC share the SCLK synchroniser latency, so they are stable at the detected edge.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    byte_d  = byte_q;
    dc_d    = dc_q;
    err_d   = err_q;
    if (cs_s) begin
      cnt_d = 3'd0;
      if (cnt_q != 3'd0) err_d = 1'b1;
    end else if (sclk_rise) begin
      shift_d = {shift_q[5:0], sdin_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        valid_d = 1'b1;
        byte_d  = {shift_q, sdin_s};
        dc_d    = dc_s;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b11;
      sdin_sync_q <= 2'b00;
      dc_sync_q   <= 2'b00;
      sclk_prev_q <= 1'b1;
      shift_q     <= 7'd0;
      cnt_q       <= 3'd0;
      valid_q     <= 1'b0;
      byte_q      <= 8'd0;
      dc_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs_i};
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      sdin_sync_q <= {sdin_sync_q[0], sdin_i};
      dc_sync_q   <= {dc_sync_q[0], dc_i};
      sclk_prev_q <= sclk_s;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      dc_q        <= dc_d;
      err_q       <= err_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign byte_dc_o    = dc_q;
  assign frame_err_o  = err_q;

endmodule

`default_nettype wire

// File: rtl/oled_spi_sink.sv
//==============================================================================
// Module      : oled_spi_sink
// Description : OLED controller SPI sink: command decode, page/column
//               addressing and framebuffer write strobe generation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int CLK_PER_SCLK_MIN = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CS,
  input  logic                 SCLK,
  input  logic                 SDIN,
  input  logic                 DC,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic [7:0]           FB_DATA,
  output logic                 FB_WE,
  output logic                 CMD_VALID,
  output logic [7:0]           CMD_BYTE,
  output logic                 DISPLAY_ON,
  output logic                 FRAME_ERR
);

  // Edge detection through two synchronisers needs at least two CLK per SCLK level.
  if (CLK_PER_SCLK_MIN < 2) begin : g_rate_check
    $error("oled_spi_sink: CLK_PER_SCLK_MIN must be at least 2");
  end

  localparam logic [0:0] ST_IDLE_CMD = 1'b0;
  localparam logic [0:0] ST_PAGE_ARG = 1'b1;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_byte_rx u_rx (
    .clk_i        (CLK),
    .rst_ni       (RST),
    .cs_i         (CS),
    .sclk_i       (SCLK),
    .sdin_i       (SDIN),
    .dc_i         (DC),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .byte_dc_o    (rx_dc),
    .frame_err_o  (FRAME_ERR)
  );

  logic [0:0]           state_q, state_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 disp_q, disp_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]           fb_data_q, fb_data_d;
  logic                 fb_we_q, fb_we_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [7:0]           cmd_byte_q, cmd_byte_d;

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    col_d       = col_q;
    disp_d      = disp_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    fb_we_d     = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    if (rx_valid) begin
      if (rx_dc) begin
        // Column wraps within the page; page is never advanced by data.
        fb_we_d   = 1'b1;
        fb_addr_d = {page_q, col_q};
        fb_data_d = rx_byte;
        col_d     = col_q + 7'd1;
        state_d   = ST_IDLE_CMD;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = rx_byte;
        if (state_q == ST_PAGE_ARG) begin
          page_d  = rx_byte[PAGE_W-1:0];
          state_d = ST_IDLE_CMD;
        end else if (is_col_lo(rx_byte)) begin
          col_d[3:0] = rx_byte[3:0];
        end else if (is_col_hi(rx_byte)) begin
          col_d[6:4] = rx_byte[2:0];
        end else if (is_page_set(rx_byte)) begin
          page_d = rx_byte[PAGE_W-1:0];
        end else if (rx_byte == CMD_DISPLAY_OFF) begin
          disp_d = 1'b0;
        end else if (rx_byte == CMD_DISPLAY_ON) begin
          disp_d = 1'b1;
        end else if (rx_byte == CMD_PAGE_ADDR) begin
          state_d = ST_PAGE_ARG;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE_CMD;
      page_q      <= '0;
      col_q       <= '0;
      disp_q      <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= 8'd0;
      fb_we_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      col_q       <= col_d;
      disp_q      <= disp_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fb_we_q     <= fb_we_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
    end
  end

  assign FB_ADDR    = fb_addr_q;
  assign FB_DATA    = fb_data_q;
  assign FB_WE      = fb_we_q;
  assign CMD_VALID  = cmd_valid_q;
  assign CMD_BYTE   = cmd_byte_q;
  assign DISPLAY_ON = disp_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_sink.sv
//==============================================================================
// Module      : tb_oled_spi_sink
// Description : Self-checking bench for oled_spi_sink with a behavioural
//               reference model of addressing and command effects.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_oled_spi_sink;

  logic       CLK = 1'b0;
  logic       RST, CS, SCLK, SDIN, DC;
  logic [8:0] FB_ADDR;
  logic [7:0] FB_DATA;
  logic       FB_WE;
  logic       CMD_VALID;
  logic [7:0] CMD_BYTE;
  logic       DISPLAY_ON;
  logic       FRAME_ERR;

  always #5 CLK = ~CLK;

  oled_spi_sink #(.CLK_PER_SCLK_MIN(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CS         (CS),
    .SCLK       (SCLK),
    .SDIN       (SDIN),
    .DC         (DC),
    .FB_ADDR    (FB_ADDR),
    .FB_DATA    (FB_DATA),
    .FB_WE      (FB_WE),
    .CMD_VALID  (CMD_VALID),
    .CMD_BYTE   (CMD_BYTE),
    .DISPLAY_ON (DISPLAY_ON),
    .FRAME_ERR  (FRAME_ERR)
  );

  int total = 0;
  int bad   = 0;

  logic [16:0] got_wr[$];
  logic [16:0] exp_wr[$];
  logic [7:0]  got_cmd[$];
  logic [7:0]  exp_cmd[$];

  // Reference model state
  int m_page, m_col;
  bit m_disp, m_err, m_arg;

  always @(negedge CLK) begin
    if (RST) begin
      if (FB_WE)     got_wr.push_back({FB_ADDR, FB_DATA});
      if (CMD_VALID) got_cmd.push_back(CMD_BYTE);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_page = 0; m_col = 0; m_disp = 0; m_err = 0; m_arg = 0;
    exp_wr.delete(); exp_cmd.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit d);
    int v;
    logic [1:0] p;
    logic [6:0] c;
    v = b;
    if (d) begin
      p = m_page[1:0];
      c = m_col[6:0];
      exp_wr.push_back({p, c, b});
      m_col = (m_col + 1) % 128;
      m_arg = 0;
    end else begin
      exp_cmd.push_back(b);
      if (m_arg) begin
        m_page = v % 4;
        m_arg  = 0;
      end else if (v < 16)                m_col  = (m_col / 16) * 16 + v;
      else if (v < 24)                    m_col  = (v - 16) * 16 + m_col % 16;
      else if (v >= 'hB0 && v <= 'hB3)    m_page = v - 'hB0;
      else if (v == 'hAE)                 m_disp = 0;
      else if (v == 'hAF)                 m_disp = 1;
      else if (v == 'h22)                 m_arg  = 1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit d, input int half, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      SCLK = 1'b0; SDIN = b[i]; DC = d;
      wait_clk(half);
      SCLK = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit d, input int half);
    send_bits(b, d, half, 8);
    model_byte(b, d);
  endtask

  task automatic cs_lo();
    CS = 1'b0;
    wait_clk(3);
  endtask

  task automatic cs_hi();
    wait_clk(3);
    CS = 1'b1;
    wait_clk(3);
  endtask

  task automatic drain(input string tag);
    int n;
    wait_clk(20);
    @(negedge CLK);
    chk({tag, "_nwr"}, got_wr.size(), exp_wr.size());
    chk({tag, "_ncmd"}, got_cmd.size(), exp_cmd.size());
    n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, got_wr[i], exp_wr[i]);
    n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) chk({tag, "_cmd"}, got_cmd[i], exp_cmd[i]);
    chk({tag, "_disp"}, DISPLAY_ON, m_disp);
    chk({tag, "_ferr"}, FRAME_ERR, m_err);
    got_wr.delete(); exp_wr.delete(); got_cmd.delete(); exp_cmd.delete();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge CLK);
    chk({tag, "_addr"}, FB_ADDR, 9'h0);
    chk({tag, "_data"}, FB_DATA, 8'h0);
    chk({tag, "_we"}, FB_WE, 1'b0);
    chk({tag, "_cv"}, CMD_VALID, 1'b0);
    chk({tag, "_cb"}, CMD_BYTE, 8'h0);
    chk({tag, "_disp"}, DISPLAY_ON, 1'b0);
    chk({tag, "_ferr"}, FRAME_ERR, 1'b0);
  endtask

  function automatic logic [7:0] rand_cmd();
    logic [7:0] r;
    case ($urandom % 6)
      0: r = 8'($urandom);
      1: r = 8'($urandom % 16);
      2: r = 8'(8'h10 + $urandom % 8);
      3: r = 8'(8'hB0 + $urandom % 4);
      4: r = 8'h22;
      default: r = 8'(8'hAE + $urandom % 2);
    endcase
    return r;
  endfunction

  initial begin
    RST = 1'b0; CS = 1'b1; SCLK = 1'b1; SDIN = 1'b0; DC = 1'b0;
    model_reset();
    wait_clk(5);
    chk_reset_outputs("rst");
    RST = 1'b1;
    wait_clk(5);

    // Display on, page 2, column 0x35, then one data byte
    cs_lo();
    send_byte(8'hAF, 0, 4);
    send_byte(8'hB2, 0, 4);
    send_byte(8'h05, 0, 4);
    send_byte(8'h13, 0, 4);
    send_byte(8'h5A, 1, 4);
    cs_hi();
    chk("basic_addr_model", {exp_wr[0][16:8]}, 9'h135);
    drain("basic");

    // Page via 0x22 argument, column wrap over 130 back-to-back data bytes
    cs_lo();
    send_byte(8'h22, 0, 4);
    send_byte(8'h03, 0, 4);
    send_byte(8'h00, 0, 4);
    send_byte(8'h10, 0, 4);
    for (int i = 0; i < 130; i++) send_byte(8'($urandom), 1, 4);
    cs_hi();
    drain("wrap");

    // Partial byte then a full command byte
    cs_lo();
    send_bits(8'hFF, 1, 4, 5);
    cs_hi();
    m_err = 1;
    cs_lo();
    send_byte(8'hAE, 0, 4);
    cs_hi();
    drain("ferr");

    // Data byte in place of page argument, then check column command is decoded
    cs_lo();
    send_byte(8'hB1, 0, 4);
    send_byte(8'h22, 0, 4);
    send_byte(8'h77, 1, 5);
    send_byte(8'h05, 0, 4);
    send_byte(8'h3C, 1, 4);
    cs_hi();
    drain("pgarg");

    // SCLK activity while deselected, then reset in the middle of a byte
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0; SDIN = 1'($urandom); wait_clk(4);
      SCLK = 1'b1; wait_clk(4);
    end
    cs_lo();
    send_bits(8'hA5, 1, 4, 4);
    SCLK = 1'b0; SDIN = 1'b0;
    wait_clk(2);
    RST = 1'b0;
    CS = 1'b1; SCLK = 1'b1;
    chk_reset_outputs("midrst");
    wait_clk(4);
    RST = 1'b1;
    model_reset();
    chk("midrst_nwr", got_wr.size(), 0);
    got_wr.delete(); got_cmd.delete();
    wait_clk(4);
    cs_lo();
    send_byte(8'hC3, 1, 4);
    cs_hi();
    drain("postrst");

    // Randomised traffic
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 16);
      cs_lo();
      for (int k = 0; k < n; k++) begin
        if ($urandom % 2) send_byte(8'($urandom), 1, $urandom_range(4, 7));
        else              send_byte(rand_cmd(), 0, $urandom_range(4, 7));
      end
      cs_hi();
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
